serv_alu_seq: RTL and testbench
===============================

# serv_alu_seq

Bit-serial operand sequencer for the serial ALU. It accepts a parallel command carrying two W-bit operands, rotates them out LSB-first over one or two W-cycle passes, and drives the ALU's init/enable/shamt strobes. It deserializes the ALU's serial result back into a W-bit word, samples the compare flag, and hands both out through a valid/ready port. It sits between a parallel issue stage or test harness and the bit-serial datapath.

## Interface
- W, default 32: operand width; power of two, 8..64
- clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset; asynchronous, active-high
- i_cmd_valid  in  1  command offered
- o_cmd_ready  out  1  sequencer idle, command accepted when both high
- i_rs1  in  W  operand A, sampled on accept
- i_op_b  in  W  operand B, sampled on accept
- i_two_pass  in  1  run an INIT pass before the EXEC pass (compare/shift ops)
- i_shamt_op  in  1  shift op; enables o_shamt_en during INIT
- o_init  out  1  INIT pass active (to ALU i_init)
- o_en  out  1  EXEC pass active (to ALU i_en)
- o_shamt_en  out  1  shamt capture strobe
- o_rs1  out  1  serial operand A, current bit
- o_op_b  out  1  serial operand B, current bit
- i_rd  in  1  serial ALU result
- i_cmp  in  1  ALU compare output
- o_res_valid  out  1  result available
- i_res_ready  in  1  result consumed when both high
- o_res  out  W  deserialized result
- o_cmp  out  1  latched compare flag

## Operation
- States: IDLE, INIT, EXEC, DONE. Bit counter cnt, width log2(W).
- IDLE: o_cmd_ready=1. On accept, load operand rotators, latch i_two_pass/i_shamt_op, cnt:=0; next state INIT if i_two_pass else EXEC.
- INIT: o_init=1. Each cycle the rotators rotate right by one (bit 0 re-enters at MSB), so operands are restored after W cycles. o_shamt_en=1 when i_shamt_op and cnt<5. At cnt==W-1: latch o_cmp<=i_cmp, cnt:=0, go to EXEC.
- EXEC: o_en=1. Rotate as in INIT. The result shift register shifts right with i_rd entering at MSB. At cnt==W-1: if single-pass, latch o_cmp<=i_cmp; go to DONE.
- DONE: o_res_valid=1; o_res and o_cmp held stable. On i_res_ready, go to IDLE.
- o_rs1/o_op_b = bit 0 of the rotators. They are driven in every state, but are meaningful only in INIT/EXEC.
- A command offered outside IDLE is not accepted; i_cmd_valid is ignored until o_cmd_ready.
- cnt wraps W-1 -> 0 on a pass boundary; no other wrap occurs.

## Timing
- Reset (async, immediate) values: state IDLE, o_cmd_ready=1, o_init=0, o_en=0, o_shamt_en=0, o_res_valid=0, o_res=0, o_cmp=0, o_rs1=0, o_op_b=0, cnt=0.
- Accept at cycle 0. Bit 0 is presented at cycle 1, the first INIT/EXEC cycle.
- Single-pass: EXEC cycles 1..W; o_res_valid first high at cycle W+1.
- Two-pass: INIT cycles 1..W, EXEC cycles W+1..2W; o_res_valid at cycle 2W+1.
- Minimum turnaround: result accepted at cycle t gives IDLE at t+1. Throughput is one command per W+2 or 2W+2 cycles.
- Same-cycle i_res_ready and i_cmd_valid in DONE: result handshake only; the command waits one cycle.
- Reset asserted mid-pass: all strobes drop immediately and the partial result is discarded. The first command is accepted on the first clock edge after deassertion.

## Structure
- Shared package entries: state encoding (IDLE/INIT/EXEC/DONE) and the shamt-capture length constant (5).
- One natural sub-module, ser_rot: a W-bit loadable right-rotator with serial bit-0 output. It is instantiated twice, once for rs1 and once for op_b.
- The result deserializer and the counter stay inline.

## Test plan
Bench model: i_rd = o_rs1 ^ o_op_b; i_cmp driven by the bench. W=32 throughout.
- Single-pass, rs1=0x0000_00F0, op_b=0x0000_0FF0 -> o_en high exactly cycles 1..32; o_res=0x0000_0F00, o_res_valid at cycle 33.
- Two-pass, rs1=0x8000_0001, op_b=0 -> serial stream on o_rs1 identical in INIT and EXEC; o_res=0x8000_0001 at cycle 65. i_cmp=1 only at INIT cnt=31 -> o_cmp=1.
- i_shamt_op=1, two-pass -> o_shamt_en high exactly cycles 1..5; stays low for i_shamt_op=0.
- Backpressure: hold i_res_ready=0 for 10 cycles in DONE with i_cmd_valid=1 -> o_res stable, o_cmd_ready=0, no second accept. i_res_ready=1 -> IDLE next cycle, accept the cycle after.
- Reset asserted at EXEC cnt=17 -> o_en, o_res_valid, o_res go to 0 without a clock edge. A new command after deassert completes with a correct result.
- Back-to-back: five random single-pass commands with i_res_ready tied high -> each result equals rs1^op_b; spacing between accepts is 34 cycles.

Source files
------------

// File: rtl/serv_alu_seq_pkg.sv
// Shared definitions for the bit-serial operand sequencer.
package serv_alu_seq_pkg;

  // Sequencer phases: wait for a command, optional INIT pass, EXEC pass, hold result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Number of leading INIT cycles that feed the ALU shift-amount register.
  localparam int unsigned SHAMT_LEN = 5;

endpackage

// File: rtl/serv_alu_seq_ser_rot.sv
// W-bit loadable right-rotator; bit 0 is the serial output. After W shifts the
// stored word is back in its original position, so it can be replayed.
module serv_alu_seq_ser_rot #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         bit_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Next rotator contents: a parallel load has priority over rotation.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = data_i;
    end else if (shift_i) begin
      data_d = {data_q[0], data_q[W-1:1]};
    end else begin
      data_d = data_q;
    end
  end

  // Rotator storage with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign bit_o = data_q[0];

endmodule

// File: rtl/serv_alu_seq.sv
// Bit-serial operand sequencer: accepts two parallel operands, streams them
// LSB-first to the serial ALU over one or two passes, and collects the serial
// result back into a parallel word offered on a valid/ready port.
module serv_alu_seq
  import serv_alu_seq_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_cmd_valid,
  output logic         o_cmd_ready,
  input  logic [W-1:0] i_rs1,
  input  logic [W-1:0] i_op_b,
  input  logic         i_two_pass,
  input  logic         i_shamt_op,
  output logic         o_init,
  output logic         o_en,
  output logic         o_shamt_en,
  output logic         o_rs1,
  output logic         o_op_b,
  input  logic         i_rd,
  input  logic         i_cmp,
  output logic         o_res_valid,
  input  logic         i_res_ready,
  output logic [W-1:0] o_res,
  output logic         o_cmp
);

  localparam int CNT_W = $clog2(W);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               two_pass_q;
  logic               shamt_op_q;
  logic [W-1:0]       res_q;
  logic               cmp_q;
  logic               cmd_ready_q;
  logic               init_q;
  logic               en_q;
  logic               shamt_en_q;
  logic               res_valid_q;

  logic               load_s;
  logic               shift_s;
  logic               cnt_last_s;

  assign load_s     = (state_q == ST_IDLE) && i_cmd_valid;
  assign shift_s    = (state_q == ST_INIT) || (state_q == ST_EXEC);
  assign cnt_last_s = (cnt_q == CNT_W'(W - 1));

  serv_alu_seq_ser_rot #(.W(W)) u_rot_rs1 (
    .clk_i   (clk),
    .rst_i   (i_rst),
    .load_i  (load_s),
    .shift_i (shift_s),
    .data_i  (i_rs1),
    .bit_o   (o_rs1)
  );

  serv_alu_seq_ser_rot #(.W(W)) u_rot_op_b (
    .clk_i   (clk),
    .rst_i   (i_rst),
    .load_i  (load_s),
    .shift_i (shift_s),
    .data_i  (i_op_b),
    .bit_o   (o_op_b)
  );

  // Sequencer FSM with bit counter, result deserializer and registered strobes.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      two_pass_q  <= 1'b0;
      shamt_op_q  <= 1'b0;
      res_q       <= '0;
      cmp_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      init_q      <= 1'b0;
      en_q        <= 1'b0;
      shamt_en_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            two_pass_q  <= i_two_pass;
            shamt_op_q  <= i_shamt_op;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            if (i_two_pass) begin
              state_q    <= ST_INIT;
              init_q     <= 1'b1;
              shamt_en_q <= i_shamt_op;
            end else begin
              state_q <= ST_EXEC;
              en_q    <= 1'b1;
            end
          end
        end
        ST_INIT: begin
          if (cnt_last_s) begin
            cmp_q      <= i_cmp;
            cnt_q      <= '0;
            state_q    <= ST_EXEC;
            init_q     <= 1'b0;
            en_q       <= 1'b1;
            shamt_en_q <= 1'b0;
          end else begin
            cnt_q      <= cnt_q + CNT_W'(1);
            // Strobe covers the first SHAMT_LEN cycles, i.e. cnt 0..SHAMT_LEN-1.
            shamt_en_q <= shamt_op_q && (cnt_q < CNT_W'(SHAMT_LEN - 1));
          end
        end
        ST_EXEC: begin
          res_q <= {i_rd, res_q[W-1:1]};
          if (cnt_last_s) begin
            if (!two_pass_q) begin
              cmp_q <= i_cmp;
            end
            cnt_q       <= '0;
            state_q     <= ST_DONE;
            en_q        <= 1'b0;
            res_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          // A command offered in this cycle waits: the port reopens next cycle.
          if (i_res_ready) begin
            state_q     <= ST_IDLE;
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cnt_q       <= '0;
          cmd_ready_q <= 1'b1;
          init_q      <= 1'b0;
          en_q        <= 1'b0;
          shamt_en_q  <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_init      = init_q;
  assign o_en        = en_q;
  assign o_shamt_en  = shamt_en_q;
  assign o_res_valid = res_valid_q;
  assign o_res       = res_q;
  assign o_cmp       = cmp_q;

endmodule

// File: tb/tb_serv_alu_seq.sv
// Self-checking bench for serv_alu_seq: the ALU is modelled as rd = rs1 ^ op_b,
// and every expectation comes from operand values and cycle positions.
module tb_serv_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         i_rst;
  logic         i_cmd_valid;
  logic         o_cmd_ready;
  logic [W-1:0] i_rs1;
  logic [W-1:0] i_op_b;
  logic         i_two_pass;
  logic         i_shamt_op;
  logic         o_init;
  logic         o_en;
  logic         o_shamt_en;
  logic         o_rs1;
  logic         o_op_b;
  logic         i_rd;
  logic         i_cmp;
  logic         o_res_valid;
  logic         i_res_ready;
  logic [W-1:0] o_res;
  logic         o_cmp;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = 0;

  serv_alu_seq #(.W(W)) dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_rs1       (i_rs1),
    .i_op_b      (i_op_b),
    .i_two_pass  (i_two_pass),
    .i_shamt_op  (i_shamt_op),
    .o_init      (o_init),
    .o_en        (o_en),
    .o_shamt_en  (o_shamt_en),
    .o_rs1       (o_rs1),
    .o_op_b      (o_op_b),
    .i_rd        (i_rd),
    .i_cmp       (i_cmp),
    .o_res_valid (o_res_valid),
    .i_res_ready (i_res_ready),
    .o_res       (o_res),
    .o_cmp       (o_cmp)
  );

  // Serial ALU stand-in: XOR of the two operand bits.
  assign i_rd = o_rs1 ^ o_op_b;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0b exp=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%08h exp=%08h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from IDLE and check every cycle up to the return to IDLE.
  // cmp_at: cycle (1-based, counted from the accept) where i_cmp pulses, 0 = never.
  task automatic run_cmd(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic two, input logic shamt, input int cmp_at,
                         input int ready_delay, input logic hold_valid);
    int n;
    logic [W-1:0] exp_res;
    logic exp_cmp;
    n       = two ? 2 * W : W;
    exp_res = a ^ b;
    exp_cmp = (cmp_at == W);
    chk1("idle_ready", o_cmd_ready, 1'b1);
    i_cmd_valid = 1'b1;
    i_rs1       = a;
    i_op_b      = b;
    i_two_pass  = two;
    i_shamt_op  = shamt;
    i_cmp       = 1'b0;
    i_res_ready = 1'b0;
    last_acc    = cyc;
    step();
    i_rs1      = $urandom;
    i_op_b     = $urandom;
    i_two_pass = ~two;
    i_shamt_op = ~shamt;
    for (int k = 1; k <= n; k++) begin
      int bitn;
      bitn = (k - 1) % W;
      i_cmp = (k == cmp_at);
      i_cmd_valid = 1'b1;
      chk1("init", o_init, two && (k <= W));
      chk1("en", o_en, !two || (k > W));
      chk1("shamt_en", o_shamt_en, two && shamt && (k <= 5));
      chk1("rs1_bit", o_rs1, a[bitn]);
      chk1("opb_bit", o_op_b, b[bitn]);
      chk1("busy_ready", o_cmd_ready, 1'b0);
      chk1("busy_valid", o_res_valid, 1'b0);
      step();
    end
    i_cmp = 1'b0;
    i_cmd_valid = hold_valid;
    for (int d = 0; d < ready_delay; d++) begin
      chk1("hold_valid", o_res_valid, 1'b1);
      chkw("hold_res", o_res, exp_res);
      chk1("hold_cmp", o_cmp, exp_cmp);
      chk1("hold_cmd_ready", o_cmd_ready, 1'b0);
      chk1("hold_en", o_en, 1'b0);
      step();
    end
    chk1("res_valid", o_res_valid, 1'b1);
    chkw("res", o_res, exp_res);
    chk1("cmp", o_cmp, exp_cmp);
    chk1("done_cmd_ready", o_cmd_ready, 1'b0);
    i_res_ready = 1'b1;
    step();
    i_res_ready = 1'b0;
    chk1("back_idle_ready", o_cmd_ready, 1'b1);
    chk1("back_idle_valid", o_res_valid, 1'b0);
    chk1("back_idle_en", o_en, 1'b0);
    chk1("back_idle_init", o_init, 1'b0);
    i_cmd_valid = 1'b0;
  endtask

  initial begin
    int prev;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    i_rst       = 1'b0;
    i_cmd_valid = 1'b0;
    i_rs1       = '0;
    i_op_b      = '0;
    i_two_pass  = 1'b0;
    i_shamt_op  = 1'b0;
    i_cmp       = 1'b0;
    i_res_ready = 1'b0;
    #1 i_rst = 1'b1;
    #1;
    chk1("rst_cmd_ready", o_cmd_ready, 1'b1);
    chk1("rst_init", o_init, 1'b0);
    chk1("rst_en", o_en, 1'b0);
    chk1("rst_shamt_en", o_shamt_en, 1'b0);
    chk1("rst_res_valid", o_res_valid, 1'b0);
    chkw("rst_res", o_res, 32'h0000_0000);
    chk1("rst_cmp", o_cmp, 1'b0);
    chk1("rst_rs1", o_rs1, 1'b0);
    chk1("rst_op_b", o_op_b, 1'b0);
    step();
    step();
    i_rst = 1'b0;

    // Single pass, fixed operands.
    run_cmd(32'h0000_00F0, 32'h0000_0FF0, 1'b0, 1'b0, 0, 0, 1'b0);
    // Two pass, compare pulse at the last INIT cycle is latched.
    run_cmd(32'h8000_0001, 32'h0000_0000, 1'b1, 1'b0, W, 0, 1'b0);
    // Two pass shift op; compare pulse at last EXEC cycle must not be latched.
    run_cmd(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b1, 2 * W, 0, 1'b0);
    // Single pass compare latched at the last EXEC cycle.
    run_cmd(32'hDEAD_BEEF, 32'h0000_FFFF, 1'b0, 1'b0, W, 0, 1'b0);
    // Backpressure: 10 stalled DONE cycles with a command pending.
    ra = $urandom;
    rb = $urandom;
    run_cmd(ra, rb, 1'b1, 1'b1, 0, 10, 1'b1);
    prev = last_acc;
    // Pending command is taken on the first IDLE cycle.
    run_cmd(32'hA5A5_A5A5, 32'h5A5A_0000, 1'b0, 1'b0, 0, 0, 1'b0);
    chki("backpressure_turnaround", last_acc - prev, 2 * W + 2 + 10);

    // Reset in the middle of an EXEC pass at cnt 17.
    i_cmd_valid = 1'b1;
    i_rs1       = 32'hFFFF_FFFF;
    i_op_b      = 32'h0000_0000;
    i_two_pass  = 1'b0;
    i_shamt_op  = 1'b0;
    step();
    i_cmd_valid = 1'b0;
    for (int k = 1; k < 18; k++) step();
    chk1("pre_rst_en", o_en, 1'b1);
    #2 i_rst = 1'b1;
    #1;
    chk1("mid_rst_en", o_en, 1'b0);
    chk1("mid_rst_valid", o_res_valid, 1'b0);
    chkw("mid_rst_res", o_res, 32'h0000_0000);
    chk1("mid_rst_ready", o_cmd_ready, 1'b1);
    chk1("mid_rst_rs1", o_rs1, 1'b0);
    step();
    i_rst = 1'b0;
    ra = $urandom;
    rb = $urandom;
    run_cmd(ra, rb, 1'b0, 1'b0, 0, 0, 1'b0);

    // Back-to-back random single-pass commands; accepts W+2 cycles apart.
    for (int i = 0; i < 5; i++) begin
      ra = $urandom;
      rb = $urandom;
      prev = last_acc;
      run_cmd(ra, rb, 1'b0, 1'b0, 0, 0, 1'b0);
      if (i > 0) chki("b2b_spacing", last_acc - prev, W + 2);
    end

    // Random two-pass commands with random compare pulse position.
    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_cmd(ra, rb, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(W - 1, W + 1)), 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
